// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state type, sizing helpers and round-robin pick function for sram_arbiter.
package sram_arb_pkg;
  localparam int MAXN = 8;
  localparam int PTR_W = 3;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  function automatic int burst_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction
  // First set bit of req at or after ptr, wrapping at n; zero when req is empty.
  function automatic logic [MAXN-1:0] rr_pick(input logic [MAXN-1:0] req, input logic [PTR_W-1:0] ptr, input int n);
    logic [PTR_W-1:0] k;
    rr_pick = '0;
    for (int j = 0; j < MAXN; j++) begin
      k = PTR_W'((int'(ptr) + j) % n);
      if (j < n && rr_pick == '0 && req[k]) rr_pick[k] = 1'b1;
    end
  endfunction
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester-side and SRAM-side signals of the arbiter.
// Modports: master (requesters + SRAM model drive inputs), slave (the arbiter).
interface sram_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0] req, lock, we, gnt, rvalid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] rdata, mem_din, mem_dout;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic mem_cs, mem_we;
  modport master (output req, lock, we, addr, din, mem_dout,
                  input gnt, rvalid, rdata, mem_cs, mem_we, mem_addr, mem_din);
  modport slave (input req, lock, we, addr, din, mem_dout,
                 output gnt, rvalid, rdata, mem_cs, mem_we, mem_addr, mem_din);
endinterface

// File: rtl/sram_arbiter_rr_picker.sv
// rr_picker: combinational masked priority encoder.
// Ports: req_i requests, ptr_i round-robin start index, gnt_o one-hot winner (zero if no request).
module rr_picker
  import sram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);
  assign gnt_o = N'(rr_pick(MAXN'(req_i), ptr_i, N));
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters.
// Ports: clk, rst_n (async active-low), bus (sram_arbiter_if.slave: req/lock/we/addr/din in,
// gnt/rvalid/rdata out, mem_cs/mem_we/mem_addr/mem_din to the SRAM, mem_dout from it).
// Build option: SRAM_ARB_FIXED_PRIO_EN gives requester 0 absolute priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic rst_n,
  sram_arbiter_if.slave bus
);
  localparam int BW = burst_w(MAX_BURST);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST - 1);
  arb_state_t state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d, xfer, pick;
  logic [PTR_W-1:0] ptr_q, ptr_d, pick_nxt;
  logic [BW-1:0] cnt_q, cnt_d;
  logic hold, rr_new;

  rr_picker #(.N(NUM_REQ)) u_rr_picker (.req_i(bus.req), .ptr_i(ptr_q), .gnt_o(pick));

  // A stale grant (owner dropped req) never touches the memory.
  assign xfer = gnt_q & bus.req;
  // Owner keeps the port while locked, unless its burst is used up and someone else waits.
  assign hold = state_q == BUSY && |(xfer & bus.lock) && (cnt_q < BMAX || (bus.req & ~gnt_q) == '0);

  always_comb begin
    pick_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
  end

  always_comb begin
    state_d = |bus.req ? BUSY : IDLE;
    rr_new = |bus.req && !hold;
    gnt_d = hold ? gnt_q : pick;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    if (bus.req[0]) begin
      gnt_d = NUM_REQ'(1);
      rr_new = 1'b0;
    end
`endif
    ptr_d = rr_new ? pick_nxt : ptr_q;
    cnt_d = (state_d == IDLE || gnt_d != gnt_q) ? '0 : (|xfer && cnt_q < BMAX) ? cnt_q + 1'b1 : cnt_q;
    rvalid_d = xfer & ~bus.we;
  end

  always_comb begin
    bus.mem_addr = '0;
    bus.mem_din = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (xfer[i]) begin
        bus.mem_addr = ADDR_WIDTH'(bus.addr >> (i * ADDR_WIDTH));
        bus.mem_din = DATA_WIDTH'(bus.din >> (i * DATA_WIDTH));
      end
  end

  assign bus.mem_cs = |xfer;
  assign bus.mem_we = |(xfer & bus.we);
  assign bus.gnt = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata = bus.mem_dout;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rvalid_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rvalid_q <= rvalid_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
endmodule
